// File: rtl/mac_dot_driver.sv
// mac_dot_driver
//   Initiator-side sequencer for a streaming multiply-accumulate unit.
//   Takes (a, b, last) operand pairs, issues a*b + acc to the MAC on three
//   independent valid/ready channels, feeds each MAC result back as the next
//   accumulator operand, and emits one dot product (plus element count) per
//   vector.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   dot__a/b/last/ab_vld/ab_rdy  operand pair input channel
//   mac__in0/in1/in2 (+vld/rdy)  MAC operand channels: a, b, running acc
//   mac__out0 (+vld/rdy)         MAC result channel
//   dot__res/res_cnt/res_vld/rdy completed dot product and element count
module mac_dot_driver #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] dot__a,
  input  logic signed [WIDTH-1:0] dot__b,
  input  logic                    dot__last,
  input  logic                    dot__ab_vld,
  output logic                    dot__ab_rdy,
  output logic signed [WIDTH-1:0] mac__in0,
  output logic                    mac__in0_vld,
  input  logic                    mac__in0_rdy,
  output logic signed [WIDTH-1:0] mac__in1,
  output logic                    mac__in1_vld,
  input  logic                    mac__in1_rdy,
  output logic signed [WIDTH-1:0] mac__in2,
  output logic                    mac__in2_vld,
  input  logic                    mac__in2_rdy,
  input  logic signed [WIDTH-1:0] mac__out0,
  input  logic                    mac__out0_vld,
  output logic                    mac__out0_rdy,
  output logic signed [WIDTH-1:0] dot__res,
  output logic [CNT_W-1:0]        dot__res_cnt,
  output logic                    dot__res_vld,
  input  logic                    dot__res_rdy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] a_r;
  logic signed [WIDTH-1:0] b_r;
  logic                    last_r;
  logic [CNT_W-1:0]        cnt;
  logic [2:0]              sent;
  logic [2:0]              xfer;
  logic                    issue_done;

  // Element counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  // Per-channel transfer this cycle; a channel counts as done once it has
  // transferred in an earlier ISSUE cycle or transfers now.
  assign xfer       = {mac__in2_vld & mac__in2_rdy,
                       mac__in1_vld & mac__in1_rdy,
                       mac__in0_vld & mac__in0_rdy};
  assign issue_done = &(sent | xfer);

  // MAC operand data is held in registers, so it cannot move while a
  // channel's valid is up.
  assign mac__in0 = a_r;
  assign mac__in1 = b_r;
  assign mac__in2 = acc;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (dot__ab_vld)   state_nxt = S_ISSUE;
      S_ISSUE:  if (issue_done)    state_nxt = S_WAIT;
      S_WAIT:   if (mac__out0_vld) state_nxt = last_r ? S_RESULT : S_IDLE;
      S_RESULT: if (dot__res_rdy)  state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // ---- outputs: functions of state and registers only, never of any
  //      MAC ready, because the MAC derives its readies from our valids ----
  always_comb begin
    dot__ab_rdy   = 1'b0;
    mac__in0_vld  = 1'b0;
    mac__in1_vld  = 1'b0;
    mac__in2_vld  = 1'b0;
    mac__out0_rdy = 1'b0;
    dot__res_vld  = 1'b0;
    dot__res      = '0;
    dot__res_cnt  = '0;
    case (state)
      S_IDLE:  dot__ab_rdy = 1'b1;
      S_ISSUE: begin
        mac__in0_vld = ~sent[0];
        mac__in1_vld = ~sent[1];
        mac__in2_vld = ~sent[2];
      end
      S_WAIT:  mac__out0_rdy = 1'b1;
      S_RESULT: begin
        dot__res_vld = 1'b1;
        dot__res     = acc;
        dot__res_cnt = cnt;
      end
      default: ;
    endcase
  end

  // ---- datapath and channel bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      sent   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      last_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dot__ab_vld) begin
            a_r    <= dot__a;
            b_r    <= dot__b;
            last_r <= dot__last;
            cnt    <= sat_inc(cnt);
          end
        end
        S_ISSUE: sent <= issue_done ? 3'b000 : (sent | xfer);
        S_WAIT: begin
          if (mac__out0_vld) acc <= mac__out0;
        end
        S_RESULT: begin
          if (dot__res_rdy) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_driver.sv
`timescale 1ns/1ps
module tb_mac_dot_driver;
  localparam int W  = 32;
  localparam int CW = 4;   // small counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  dot__a = '0;
  logic [W-1:0]  dot__b = '0;
  logic          dot__last = 1'b0;
  logic          dot__ab_vld = 1'b0;
  logic          dot__ab_rdy;
  logic [W-1:0]  mac__in0, mac__in1, mac__in2;
  logic          mac__in0_vld, mac__in1_vld, mac__in2_vld;
  logic          mac__in0_rdy, mac__in1_rdy, mac__in2_rdy;
  logic [W-1:0]  mac__out0;
  logic          mac__out0_vld;
  logic          mac__out0_rdy;
  logic [W-1:0]  dot__res;
  logic [CW-1:0] dot__res_cnt;
  logic          dot__res_vld;
  logic          dot__res_rdy = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] rdy_en = 3'b111;
  logic [2:0] rnd_rdy = 3'b111;
  bit         bp_mode = 1'b0;

  logic [W-1:0] va[$];
  logic [W-1:0] vb[$];

  always #5 clk = ~clk;

  mac_dot_driver #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dot__a(dot__a), .dot__b(dot__b), .dot__last(dot__last),
    .dot__ab_vld(dot__ab_vld), .dot__ab_rdy(dot__ab_rdy),
    .mac__in0(mac__in0), .mac__in0_vld(mac__in0_vld), .mac__in0_rdy(mac__in0_rdy),
    .mac__in1(mac__in1), .mac__in1_vld(mac__in1_vld), .mac__in1_rdy(mac__in1_rdy),
    .mac__in2(mac__in2), .mac__in2_vld(mac__in2_vld), .mac__in2_rdy(mac__in2_rdy),
    .mac__out0(mac__out0), .mac__out0_vld(mac__out0_vld), .mac__out0_rdy(mac__out0_rdy),
    .dot__res(dot__res), .dot__res_cnt(dot__res_cnt),
    .dot__res_vld(dot__res_vld), .dot__res_rdy(dot__res_rdy)
  );

  // MAC readies follow the driver's valids, optionally throttled.
  assign mac__in0_rdy = mac__in0_vld & (bp_mode ? rnd_rdy[0] : rdy_en[0]);
  assign mac__in1_rdy = mac__in1_vld & (bp_mode ? rnd_rdy[1] : rdy_en[1]);
  assign mac__in2_rdy = mac__in2_vld & (bp_mode ? rnd_rdy[2] : rdy_en[2]);

  always @(negedge clk) rnd_rdy <= 3'($urandom);

  // Behavioural MAC: collects the three operands independently, result is
  // presented two edges after the last operand arrives.
  logic [2:0]   m_have;
  logic [W-1:0] m_x0, m_x1, m_x2, m_s1, m_out;
  logic         m_s1_vld, m_out_vld;
  int n_xfer0 = 0, n_xfer1 = 0, n_xfer2 = 0, n_dup = 0;
  logic [W-1:0] in2_log[$];

  assign mac__out0     = m_out;
  assign mac__out0_vld = m_out_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have <= '0; m_s1_vld <= 1'b0; m_out_vld <= 1'b0;
      m_s1 <= '0; m_out <= '0; m_x0 <= '0; m_x1 <= '0; m_x2 <= '0;
    end else begin : mac_step
      logic [2:0]   h;
      logic [W-1:0] x0, x1, x2;
      h = m_have; x0 = m_x0; x1 = m_x1; x2 = m_x2;
      if (mac__in0_vld && mac__in0_rdy) begin
        if (h[0]) n_dup <= n_dup + 1;
        h[0] = 1'b1; x0 = mac__in0; n_xfer0 <= n_xfer0 + 1;
      end
      if (mac__in1_vld && mac__in1_rdy) begin
        if (h[1]) n_dup <= n_dup + 1;
        h[1] = 1'b1; x1 = mac__in1; n_xfer1 <= n_xfer1 + 1;
      end
      if (mac__in2_vld && mac__in2_rdy) begin
        if (h[2]) n_dup <= n_dup + 1;
        h[2] = 1'b1; x2 = mac__in2; n_xfer2 <= n_xfer2 + 1;
        in2_log.push_back(mac__in2);
      end
      if (m_out_vld && mac__out0_rdy) m_out_vld <= 1'b0;
      else if (m_s1_vld && !m_out_vld) begin
        m_out <= m_s1; m_out_vld <= 1'b1; m_s1_vld <= 1'b0;
      end
      if (h == 3'b111) begin
        m_s1 <= x0 * x1 + x2; m_s1_vld <= 1'b1; h = 3'b000;
      end
      m_have <= h; m_x0 <= x0; m_x1 <= x1; m_x2 <= x2;
    end
  end

  // Reference: sum of signed products of the first k pairs, modulo 2^W.
  function automatic logic [W-1:0] exp_prefix(input int k);
    longint s = 0;
    for (int i = 0; i < k; i++)
      s += longint'($signed(va[i])) * longint'($signed(vb[i]));
    return W'(s);
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
    if (va.size() > 15) return 4'd15;
    return CW'(va.size());
  endfunction

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic last, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    dot__a = a; dot__b = b; dot__last = last; dot__ab_vld = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (dot__ab_rdy) begin @(posedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    #1 dot__ab_vld = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout ab_rdy got 0 want 1 within 400 cycles");
    end
  endtask

  task automatic get_result(output logic [W-1:0] r, output logic [CW-1:0] c, output bit ok);
    ok = 1'b0; r = '0; c = '0;
    dot__res_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dot__res_vld) begin r = dot__res; c = dot__res_cnt; ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    #1 dot__res_rdy = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL result_timeout res_vld got 0 want 1 within 400 cycles");
    end
  endtask

  task automatic run_vector(output logic [W-1:0] r, output logic [CW-1:0] c);
    bit k;
    for (int i = 0; i < va.size(); i++) send_pair(va[i], vb[i], (i == va.size() - 1), k);
    get_result(r, c, k);
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({dot__ab_rdy, mac__in0_vld, mac__in1_vld, mac__in2_vld, mac__out0_rdy, dot__res_vld} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 100000",
               {dot__ab_rdy, mac__in0_vld, mac__in1_vld, mac__in2_vld, mac__out0_rdy, dot__res_vld});
    end
    vectors++;
    if (dot__res !== 0 || dot__res_cnt !== 0 || mac__in2 !== 0) begin
      miscompares++;
      $display("FAIL reset_data res got %h cnt %0d in2 %h want 0 0 0", dot__res, dot__res_cnt, mac__in2);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok; int lat; int s0; logic [W-1:0] r; logic [CW-1:0] c;
    s0 = in2_log.size();
    send_pair(32'd3, 32'd4, 1'b1, ok);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; lat++;
      if (dot__res_vld) break;
    end
    vectors++;
    if (lat != 4) begin miscompares++; $display("FAIL single_latency got %0d want 4", lat); end
    vectors++;
    if (in2_log.size() != s0 + 1 || in2_log[s0] !== 32'd0) begin
      miscompares++; $display("FAIL single_in2 got n=%0d v=%h want n=1 v=0", in2_log.size() - s0, in2_log[s0]);
    end
    get_result(r, c, ok);
    vectors++;
    if (r !== 32'd12 || c !== 4'd1) begin
      miscompares++; $display("FAIL single_res got %0d cnt %0d want 12 cnt 1", r, c);
    end
  endtask

  task automatic test_vector();
    int s0; logic [W-1:0] r; logic [CW-1:0] c; logic [W-1:0] want_in2[3];
    want_in2[0] = 32'd0; want_in2[1] = 32'd2; want_in2[2] = 32'd14;
    va = '{32'd1, 32'd3, 32'd5}; vb = '{32'd2, 32'd4, 32'd6};
    s0 = in2_log.size();
    run_vector(r, c);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (in2_log[s0 + i] !== want_in2[i]) begin
        miscompares++; $display("FAIL vector_in2[%0d] got %0d want %0d", i, in2_log[s0 + i], want_in2[i]);
      end
    end
    vectors++;
    if (r !== 32'd44 || c !== 4'd3) begin
      miscompares++; $display("FAIL vector_res got %0d cnt %0d want 44 cnt 3", r, c);
    end
    va = '{32'd2}; vb = '{32'd2};
    run_vector(r, c);
    vectors++;
    if (r !== 32'd4 || c !== 4'd1) begin
      miscompares++; $display("FAIL vector2_res got %0d cnt %0d want 4 cnt 1", r, c);
    end
  endtask

  task automatic test_signed_wrap();
    logic [W-1:0] r; logic [CW-1:0] c;
    va = '{32'(-2), 32'd5}; vb = '{32'd7, 32'd5};
    run_vector(r, c);
    vectors++;
    if (r !== 32'd11 || c !== 4'd2) begin
      miscompares++; $display("FAIL signed_res got %0d cnt %0d want 11 cnt 2", $signed(r), c);
    end
    va = '{32'h0001_0000}; vb = '{32'h0001_0000};
    run_vector(r, c);
    vectors++;
    if (r !== 32'h0 || c !== 4'd1) begin
      miscompares++; $display("FAIL wrap_res got %h cnt %0d want 00000000 cnt 1", r, c);
    end
  endtask

  task automatic test_partial_bp();
    bit ok; int c0, c1, c2, d0; logic [W-1:0] r; logic [CW-1:0] c;
    c0 = n_xfer0; c1 = n_xfer1; c2 = n_xfer2; d0 = n_dup;
    rdy_en = 3'b101;
    send_pair(32'd7, 32'(-3), 1'b1, ok);
    @(negedge clk);
    vectors++;
    if ({mac__in0_vld, mac__in1_vld, mac__in2_vld} !== 3'b111) begin
      miscompares++; $display("FAIL bp_first_vld got %b want 111", {mac__in0_vld, mac__in1_vld, mac__in2_vld});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({mac__in0_vld, mac__in1_vld, mac__in2_vld} !== 3'b010 || mac__in1 !== 32'(-3)) begin
        miscompares++;
        $display("FAIL bp_hold vld got %b in1 %h want 010 in1 fffffffd",
                 {mac__in0_vld, mac__in1_vld, mac__in2_vld}, mac__in1);
      end
    end
    @(posedge clk); #1 rdy_en = 3'b111;
    get_result(r, c, ok);
    vectors++;
    if (r !== 32'(-21) || c !== 4'd1) begin
      miscompares++; $display("FAIL bp_res got %0d cnt %0d want -21 cnt 1", $signed(r), c);
    end
    vectors++;
    if (n_xfer0 - c0 != 1 || n_xfer1 - c1 != 1 || n_xfer2 - c2 != 1 || n_dup != d0) begin
      miscompares++;
      $display("FAIL bp_issue_count got %0d/%0d/%0d dup %0d want 1/1/1 dup 0",
               n_xfer0 - c0, n_xfer1 - c1, n_xfer2 - c2, n_dup - d0);
    end
  endtask

  task automatic test_res_bp();
    bit ok; bit got; logic [W-1:0] r; logic [CW-1:0] c;
    dot__res_rdy = 1'b0;
    send_pair(32'd4, 32'd5, 1'b0, ok);
    send_pair(32'd6, 32'(-1), 1'b1, ok);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (dot__res_vld) got = 1'b1;
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL resbp_vld got 0 want 1"); end
    dot__a = 32'd9; dot__b = 32'd9; dot__last = 1'b1; dot__ab_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({dot__res_vld, dot__ab_rdy} !== 2'b10 || dot__res !== 32'd14 || dot__res_cnt !== 4'd2) begin
        miscompares++;
        $display("FAIL resbp_hold[%0d] vld/ab_rdy %b res %0d cnt %0d want 10 14 2",
                 k, {dot__res_vld, dot__ab_rdy}, dot__res, dot__res_cnt);
      end
      @(negedge clk);
    end
    dot__res_rdy = 1'b1;
    @(posedge clk); #1 dot__res_rdy = 1'b0;
    vectors++;
    if ({dot__res_vld, dot__ab_rdy} !== 2'b01) begin
      miscompares++; $display("FAIL resbp_release got %b want 01", {dot__res_vld, dot__ab_rdy});
    end
    @(posedge clk); #1 dot__ab_vld = 1'b0;
    vectors++;
    if (mac__in0_vld !== 1'b1 || mac__in0 !== 32'd9) begin
      miscompares++; $display("FAIL resbp_next_accept in0_vld %b in0 %0d want 1 9", mac__in0_vld, mac__in0);
    end
    get_result(r, c, ok);
    vectors++;
    if (r !== 32'd81 || c !== 4'd1) begin
      miscompares++; $display("FAIL resbp_next_res got %0d cnt %0d want 81 cnt 1", r, c);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [W-1:0] r; logic [CW-1:0] c;
    send_pair(32'd1, 32'd1, 1'b0, ok);
    send_pair(32'd2, 32'd2, 1'b0, ok);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({dot__ab_rdy, mac__in0_vld, mac__in1_vld, mac__in2_vld, mac__out0_rdy, dot__res_vld} !== 6'b100000
        || mac__in2 !== 0 || dot__res !== 0 || dot__res_cnt !== 0) begin
      miscompares++;
      $display("FAIL midreset_outputs ctrl %b in2 %h res %h cnt %0d want 100000 0 0 0",
               {dot__ab_rdy, mac__in0_vld, mac__in1_vld, mac__in2_vld, mac__out0_rdy, dot__res_vld},
               mac__in2, dot__res, dot__res_cnt);
    end
    #1 rst_n = 1'b1;
    va = '{32'd3}; vb = '{32'd3};
    run_vector(r, c);
    vectors++;
    if (r !== 32'd9 || c !== 4'd1) begin
      miscompares++; $display("FAIL midreset_res got %0d cnt %0d want 9 cnt 1", r, c);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] r; logic [CW-1:0] c;
    va.delete(); vb.delete();
    for (int i = 0; i < 20; i++) begin va.push_back($urandom); vb.push_back($urandom); end
    run_vector(r, c);
    vectors++;
    if (c !== 4'd15) begin miscompares++; $display("FAIL sat_cnt got %0d want 15", c); end
    vectors++;
    if (r !== exp_prefix(20)) begin miscompares++; $display("FAIL sat_res got %h want %h", r, exp_prefix(20)); end
  endtask

  task automatic test_random();
    logic [W-1:0] r; logic [CW-1:0] c; int n, s0, c0, c1, c2;
    bp_mode = 1'b1;
    for (int v = 0; v < 8; v++) begin
      n = $urandom_range(6, 1);
      va.delete(); vb.delete();
      for (int i = 0; i < n; i++) begin va.push_back($urandom); vb.push_back($urandom); end
      s0 = in2_log.size(); c0 = n_xfer0; c1 = n_xfer1; c2 = n_xfer2;
      run_vector(r, c);
      vectors++;
      if (r !== exp_prefix(n) || c !== exp_cnt()) begin
        miscompares++; $display("FAIL rand_res[%0d] got %h cnt %0d want %h cnt %0d", v, r, c, exp_prefix(n), exp_cnt());
      end
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (in2_log[s0 + i] !== exp_prefix(i)) begin
          miscompares++; $display("FAIL rand_in2[%0d][%0d] got %h want %h", v, i, in2_log[s0 + i], exp_prefix(i));
        end
      end
      vectors++;
      if (n_xfer0 - c0 != n || n_xfer1 - c1 != n || n_xfer2 - c2 != n) begin
        miscompares++;
        $display("FAIL rand_issue_count[%0d] got %0d/%0d/%0d want %0d", v, n_xfer0 - c0, n_xfer1 - c1, n_xfer2 - c2, n);
      end
    end
    bp_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_vector();
    test_signed_wrap();
    test_partial_bp();
    test_res_bp();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mac_dot_driver.md
Name: mac_dot_driver

Overview:
- Initiator-side sequencer that feeds the three input channels of the streaming MAC (in0, in1, in2) and consumes its out0 channel.
- Accepts a stream of (a, b) operand pairs, each tagged with a last flag. Issues a*b+acc to the MAC and feeds each MAC result back as the next in2 operand.
- Emits one dot-product result per vector. Sits between an operand source (e.g. an SRAM reader) and downstream result logic.

Parameters:
WIDTH, 32, datapath width of operands, accumulator and MAC channels
CNT_W, 16, width of the per-vector element counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
dot__a  input  WIDTH  operand a (signed two's complement)
dot__b  input  WIDTH  operand b (signed)
dot__last  input  1  pair is final element of the current vector
dot__ab_vld  input  1  operand pair valid
dot__ab_rdy  output  1  operand pair accepted this cycle (when vld high)
mac__in0  output  WIDTH  to MAC: a
mac__in0_vld  output  1  in0 valid
mac__in0_rdy  input  1  MAC accepted in0
mac__in1  output  WIDTH  to MAC: b
mac__in1_vld  output  1  in1 valid
mac__in1_rdy  input  1  MAC accepted in1
mac__in2  output  WIDTH  to MAC: running accumulator
mac__in2_vld  output  1  in2 valid
mac__in2_rdy  input  1  MAC accepted in2
mac__out0  input  WIDTH  MAC result
mac__out0_vld  input  1  MAC result valid
mac__out0_rdy  output  1  driver takes MAC result
dot__res  output  WIDTH  completed dot product
dot__res_cnt  output  CNT_W  number of elements in vector (saturating)
dot__res_vld  output  1  result valid
dot__res_rdy  input  1  downstream accepts result

Behaviour:
- Reset (async assert, sync release): state=IDLE; acc=0, cnt=0, sent[2:0]=0, a_r/b_r/last_r=0. All vld/rdy outputs 0 except dot__ab_rdy=1. dot__res=0, dot__res_cnt=0.
- Handshake rules:
  - Channel transfer occurs on a cycle where vld&rdy=1.
  - MAC rdy depends combinationally on vld. The driver's vld outputs are therefore registered/state-derived only and never depend on any mac__*_rdy.
  - Once vld is raised, vld and data stay stable until the transfer.
- IDLE:
  - dot__ab_rdy=1.
  - On dot__ab_vld, latch a, b, last; cnt<=sat(cnt+1); go to ISSUE.
- ISSUE:
  - mac__inK_vld = ~sent[K]. Data: in0=a_r, in1=b_r, in2=acc.
  - Each channel is tracked independently: sent[K]<=1 on its transfer.
  - When all three are done (including channels completing this cycle): clear sent, go to WAIT. Each channel transfers exactly once per element; no duplicates.
- WAIT:
  - mac__out0_rdy=1.
  - On mac__out0_vld: acc<=mac__out0; go to RESULT if last_r, else IDLE.
  - mac__out0_rdy=0 in all other states, so stray MAC output is held, never dropped.
- RESULT:
  - dot__res_vld=1, dot__res=acc, dot__res_cnt=cnt, dot__ab_rdy=0.
  - Outputs stay stable until dot__res_rdy. On transfer: acc<=0, cnt<=0, go to IDLE.
- Arithmetic:
  - Result is modulo 2^WIDTH (signed multiply low half, plus acc); wraps silently.
  - cnt saturates at 2^CNT_W-1.
- Timing:
  - Uncontended latency per element: accept at t, ISSUE t+1, MAC out valid t+3, captured t+3, next accept t+4. Throughput is one element per 4 cycles.
  - Final result is valid at t+4 after accepting the last pair.
- Boundary conditions:
  - Backpressure on any single mac__inK_rdy stalls only that channel's transfer. Other channels complete and drop vld.
  - dot__ab_rdy stays 0 outside IDLE.
- Reset mid-operation: immediate return to reset state; partial vector discarded. The MAC shares the reset and is flushed with it.

Test Plan:
- Single pair a=3, b=4, last=1, all rdy high -> one MAC issue with in2=0. dot__res=12, dot__res_cnt=1, res_vld exactly 4 cycles after accept.
- Vector (1,2), (3,4), (5,6, last) -> in2 sequence 0, 2, 14. dot__res=44, cnt=3. Second vector (2,2, last) then gives 4 (acc cleared).
- Signed/wrap: (-2,7), (5,5, last) -> res=11. Single pair (0x10000, 0x10000, last) -> res=0x00000000.
- Partial backpressure: hold mac__in1_rdy=0 for 3 ISSUE cycles -> in0/in2 each transfer once and drop vld; in1_vld held with stable data; result correct, no duplicate MAC issue.
- Result backpressure: dot__res_rdy=0 for 5 cycles -> res/res_cnt/res_vld stable; dot__ab_rdy=0; new pair accepted the cycle after the res transfer.
- Reset pulse during WAIT of the 2nd element -> outputs return to reset values asynchronously. A fresh vector (3,3, last) yields 9, cnt=1.
